// File: rtl/io_tx_port.sv
// Memory-mapped UART transmit endpoint: byte FIFO, stop command, cycle counter.
// Define IO_CYCLE_COUNTER_EN to build the cycle counter and its snapshot.
module io_tx_port #(
   parameter int DEPTH       = 16,
   parameter int FULL_MARGIN = 2
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic [31:0] mem_a,
   input  logic [7:0]  mem_dout,
   input  logic        mem_wr,
   output logic [7:0]  io_rdata,
   output logic        io_buffer_full,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        prog_done,
   output logic        overflow
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH);
   localparam logic [AW:0] CNT_THR = (AW+1)'(DEPTH - FULL_MARGIN);
   localparam logic [17:0] A_TX  = 18'h30000;
   localparam logic [17:0] A_CTL = 18'h30004;
   localparam logic [17:0] A_B1  = 18'h30005;
   localparam logic [17:0] A_B2  = 18'h30006;
   localparam logic [17:0] A_B3  = 18'h30007;

   logic [7:0]    ram_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          stop_req_q, stop_req_d;
   logic          prog_done_q, prog_done_d;
   logic          overflow_q, overflow_d;
   logic [7:0]    rdata_q, rdata_d;
   logic [17:0]   addr;
   logic          io_hit, bus_wr, bus_rd;
   logic          push_req, push, pop;
   logic [7:0]    push_data;
   logic          unused_addr;

   assign addr        = mem_a[17:0];
   assign unused_addr = ^mem_a[31:18];
   assign io_hit      = rdy_in && (addr[17:16] == 2'b11);
   assign bus_wr      = io_hit && mem_wr && !stop_req_q;
   assign bus_rd      = io_hit && !mem_wr;

   assign tx_valid       = (count_q != '0);
   assign tx_data        = tx_valid ? ram_q[rd_ptr_q] : 8'h00;
   assign pop            = tx_valid && tx_ready;
   assign io_buffer_full = (count_q >= CNT_THR);
   assign prog_done      = prog_done_q;
   assign overflow       = overflow_q;
   assign io_rdata       = rdata_q;

   always_comb begin
      push_req   = 1'b0;
      push_data  = mem_dout;
      stop_req_d = stop_req_q;
      if (bus_wr) begin
         if (addr == A_CTL) begin
            push_req   = 1'b1;
            push_data  = 8'h00;
            stop_req_d = 1'b1;
         end else if (addr == A_TX && mem_dout != 8'h00) begin
            push_req = 1'b1;
         end
      end
   end

   // A pop in the same cycle frees the slot, so a push at full is still taken
   always_comb begin
      push        = push_req && ((count_q != CNT_MAX) || pop);
      overflow_d  = overflow_q | (push_req && !push);
      wr_ptr_d    = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d    = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d     = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
      prog_done_d = prog_done_q | (stop_req_q && count_q == '0);
   end

   always_ff @(posedge clk_in) begin
      if (push) ram_q[wr_ptr_q] <= push_data;
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         stop_req_q  <= 1'b0;
         prog_done_q <= 1'b0;
         overflow_q  <= 1'b0;
         rdata_q     <= 8'h00;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         stop_req_q  <= stop_req_d;
         prog_done_q <= prog_done_d;
         overflow_q  <= overflow_d;
         rdata_q     <= rdata_d;
      end
   end

`ifdef IO_CYCLE_COUNTER_EN
   logic [31:0] cyc_q, cyc_d;
   logic [31:0] snap_q, snap_d;

   // Only the byte-0 read reloads snap so a 4-byte load sees one value
   always_comb begin
      cyc_d   = rdy_in ? cyc_q + 32'd1 : cyc_q;
      snap_d  = snap_q;
      rdata_d = rdata_q;
      if (bus_rd) begin
         rdata_d = 8'h00;
         if (addr == A_CTL) begin
            snap_d  = cyc_q;
            rdata_d = cyc_q[7:0];
         end else if (addr == A_B1) begin
            rdata_d = snap_q[15:8];
         end else if (addr == A_B2) begin
            rdata_d = snap_q[23:16];
         end else if (addr == A_B3) begin
            rdata_d = snap_q[31:24];
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         cyc_q  <= '0;
         snap_q <= '0;
      end else begin
         cyc_q  <= cyc_d;
         snap_q <= snap_d;
      end
   end
`else
   always_comb begin
      rdata_d = rdata_q;
      if (bus_rd) rdata_d = 8'h00;
   end
`endif

endmodule

// File: doc/io_tx_port.md
# io_tx_port

Memory-mapped I/O endpoint downstream of the CPU core's external memory bus. It decodes byte writes to 0x30000 into a transmit FIFO that drains to the UART. It decodes writes to 0x30004 as the program-stop command. It serves byte reads of 0x30004 from a free-running cycle counter. It drives `io_buffer_full` back to the core so stores are held while the FIFO lacks headroom.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; power of two, minimum 4.
- `FULL_MARGIN`, 2: free entries reserved before `io_buffer_full` asserts; range 1 to DEPTH-1.

Ports:
- `clk_in`  input  1  system clock; single clock domain.
- `rst_in`  input  1  reset; asynchronous, active-low.
- `rdy_in`  input  1  CPU ready; low means the bus is ignored and the counter holds.
- `mem_a`  input  32  CPU address bus; only [17:0] is decoded.
- `mem_dout`  input  8  CPU write data.
- `mem_wr`  input  1  1 = write, 0 = read.
- `io_rdata`  output  8  read data; valid the cycle after the read address.
- `io_buffer_full`  output  1  FIFO headroom exhausted.
- `tx_data`  output  8  FIFO head byte.
- `tx_valid`  output  1  FIFO non-empty.
- `tx_ready`  input  1  UART accepts `tx_data` this cycle.
- `prog_done`  output  1  stop command issued and the FIFO has fully drained; sticky.
- `overflow`  output  1  sticky; a push was dropped.

## Operation
- I/O hit: `mem_a[17:16]==2'b11`. A bus cycle counts only while `rdy_in`=1.
- Write to 0x30000 with `mem_dout`!=0: push `mem_dout`. Writes of 0x00 are ignored.
- Write to 0x30004: push 0x00 and set the internal flag `stop_req`.
- Once `stop_req` is set, every later write is ignored.
- A push when `count==DEPTH` is dropped and sets `overflow`, unless a pop occurs in the same cycle.
- Pop: `tx_valid && tx_ready`. It is independent of `rdy_in` so the UART drains while the CPU is paused.
- `tx_data` is first-word-fall-through: the head entry is shown directly from the RAM and the read pointer.
- Simultaneous push and pop leave `count` unchanged and both pointers advance. This holds even at count==DEPTH, and that push is accepted.
- Pointers are log2(DEPTH) bits and wrap naturally. `count` is log2(DEPTH)+1 bits.
- `io_buffer_full` = (count >= DEPTH-FULL_MARGIN). It is combinational from `count`.
- `prog_done` sets on the first cycle that `stop_req` && count==0. It stays set until reset.
- Cycle counter: 32 bits, cleared by reset, +1 per cycle while `rdy_in`=1, wraps at 2^32.
- Read of 0x30004: latch `snap` = counter and return byte 0.
- Reads of 0x30005, 0x30006 and 0x30007 return bytes 1, 2 and 3 of `snap`. `snap` is not reloaded, so a 4-byte load is coherent.
- Reads of any other I/O address return 0x00.
- Non-I/O addresses are ignored; `io_rdata` holds its value.
- The read path and the write path are both decoded in the same cycle; a cycle is either a read or a write, selected by `mem_wr`.

## Timing
- Reset values: `io_rdata`=0x00, `tx_valid`=0, `tx_data`=0x00, `io_buffer_full`=0, `prog_done`=0, `overflow`=0. Reset also clears `count`, both pointers, the counter, `snap` and `stop_req`.
- Reset takes effect immediately and asynchronously, even in the middle of a drain. FIFO contents are discarded.
- Write latency: the pushed byte appears on `tx_data` with `tx_valid`=1 in the cycle after the write edge.
- Read latency: `io_rdata` is registered and valid exactly one cycle after the read address cycle.
- `io_buffer_full` updates in the cycle after the push edge. `FULL_MARGIN` covers the core issuing stores before it sees the flag.
- `prog_done` is registered: it rises one cycle after the final pop edge.

## Configuration
- `IO_CYCLE_COUNTER_EN` defined: the counter and `snap` are built as described above.
- `IO_CYCLE_COUNTER_EN` undefined: the counter and `snap` are removed, and reads of 0x30004 through 0x30007 return 0x00. All other behaviour is unchanged.

## Test plan
- **Single write:** write 0x41 to 0x30000 with `tx_ready`=1. Required: `tx_valid` high for one cycle the next cycle with `tx_data`=0x41, then low.
- **Zero write:** write 0x00 to 0x30000. Required: no push, and `tx_valid` stays 0.
- **Back-pressure:** hold `tx_ready`=0 and write bytes 1..16 with DEPTH=16, FULL_MARGIN=2.
  - `io_buffer_full` rises after the 14th push.
  - The 17th write sets `overflow`.
  - Releasing `tx_ready` drains 1..16 in order.
- **Stop:** write 0x48 to 0x30000, then any byte to 0x30004, then 0x49 to 0x30000, with `tx_ready`=1. Required: the UART sees 0x48 then 0x00, 0x49 is never pushed, and `prog_done` rises one cycle after the 0x00 pop.
- **Counter coherence:** read 0x30004 through 0x30007 on consecutive cycles with counter=0x000000FF at the first read. Required: bytes FF, 00, 00, 00 returned. With the macro undefined, all four bytes are 00.
- **Async reset mid-drain:** pull `rst_in` low with 5 bytes queued. Required: `tx_valid`, `count` and `overflow` clear immediately. After release, the counter restarts from 0.
